// File: rtl/lu_scan_pkg.sv
// Shared definitions for the lu_scan grid/circle membership scanner:
// bus and grid defaults, field widths, mode and state encodings, circle test.
package lu_scan_pkg;

    localparam int LU_BUS_SZ = 4;
    localparam int LU_GRID   = 8;
    localparam int COORD_W   = 4;
    localparam int RAD_W     = 4;
    localparam int DIST_W    = 9;

    typedef enum logic [1:0] {
        MODE_A        = 2'd0,
        MODE_A_AND_B  = 2'd1,
        MODE_A_XOR_B  = 2'd2,
        MODE_TWO_OF_3 = 2'd3
    } lu_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } lu_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [RAD_W-1:0]   r;
    } lu_circle_t;

    // Absolute differences keep every term non-negative, so 9 bits hold the
    // worst case 15^2 + 15^2 even for centres far outside the grid.
    function automatic logic in_circle(input logic [COORD_W-1:0] px,
                                       input logic [COORD_W-1:0] py,
                                       input lu_circle_t         c);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        logic [DIST_W-1:0]  dxw;
        logic [DIST_W-1:0]  dyw;
        logic [DIST_W-1:0]  rw;
        dx  = (px >= c.x) ? (px - c.x) : (c.x - px);
        dy  = (py >= c.y) ? (py - c.y) : (c.y - py);
        dxw = DIST_W'(dx);
        dyw = DIST_W'(dy);
        rw  = DIST_W'(c.r);
        return ((dxw * dxw) + (dyw * dyw)) <= (rw * rw);
    endfunction

endpackage

// File: rtl/lu_scan_point.sv
// Combinational membership test of one grid point against three circles,
// combined according to the set-function mode.
module lu_point
    import lu_scan_pkg::*;
(
    input  logic [COORD_W-1:0] px_i,
    input  logic [COORD_W-1:0] py_i,
    input  lu_circle_t         circ_a_i,
    input  lu_circle_t         circ_b_i,
    input  lu_circle_t         circ_c_i,
    input  lu_mode_e           mode_i,
    output logic               hit_o
);

    logic       in_a;
    logic       in_b;
    logic       in_c;
    logic [1:0] n_in;

    always_comb begin
        hit_o = 1'b0;
        in_a  = in_circle(px_i, py_i, circ_a_i);
        in_b  = in_circle(px_i, py_i, circ_b_i);
        in_c  = in_circle(px_i, py_i, circ_c_i);
        n_in  = {1'b0, in_a} + {1'b0, in_b} + {1'b0, in_c};
        case (mode_i)
            MODE_A:        hit_o = in_a;
            MODE_A_AND_B:  hit_o = in_a & in_b;
            MODE_A_XOR_B:  hit_o = in_a ^ in_b;
            MODE_TWO_OF_3: hit_o = (n_in == 2'd2);
            default:       hit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/lu_scan.sv
// Scans a GRID x GRID point grid LANES points per beat and streams hit masks
// to an external accumulator. Define LU_PIPE_EN to register hit_o/acc_en_o.
//
// state | meaning
// IDLE  | waiting for en_i, parameters captured on accept
// CLEAR | one-cycle accumulator clear
// SCAN  | one hit beat per cycle, beat counter 0..BEATS-1
// DONE  | scan finished (done_o here unless pipelined)
module lu_scan
    import lu_scan_pkg::*;
#(
    parameter int LANES = LU_BUS_SZ,
    parameter int GRID  = LU_GRID
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [6*COORD_W-1:0] central_i,
    input  logic [3*RAD_W-1:0]   radius_i,
    input  logic [1:0]           mode_i,
    output logic                 busy_o,
    output logic                 acc_clear_o,
    output logic                 acc_en_o,
    output logic [LANES-1:0]     hit_o,
    output logic                 done_o
);

    localparam int BEATS  = (GRID * GRID) / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PT_W   = (GRID * GRID > 1) ? $clog2(GRID * GRID) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    lu_state_e            state_q, state_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [6*COORD_W-1:0] cen_q, cen_d;
    logic [3*RAD_W-1:0]   rad_q, rad_d;
    lu_mode_e             mode_q, mode_d;

    logic             tail_busy;
    logic             start;
    logic             scan_act;
    logic [LANES-1:0] lane_hit;
    logic [LANES-1:0] hit_comb;
    lu_circle_t       circ_a, circ_b, circ_c;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            cen_q   <= '0;
            rad_q   <= '0;
            mode_q  <= MODE_A;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cen_q   <= cen_d;
            rad_q   <= rad_d;
            mode_q  <= mode_d;
        end
    end

    // A pipelined tail still counts as busy, so a start there is dropped.
    assign start = (state_q == ST_IDLE) && en_i && !tail_busy;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cen_d   = cen_q;
        rad_d   = rad_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    beat_d  = '0;
                    cen_d   = central_i;
                    rad_d   = radius_i;
                    mode_d  = lu_mode_e'(mode_i);
                end
            end
            ST_CLEAR: state_d = ST_SCAN;
            ST_SCAN: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = ST_DONE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign circ_a = lu_circle_t'({cen_q[6*COORD_W-1 -: 2*COORD_W], rad_q[3*RAD_W-1 -: RAD_W]});
    assign circ_b = lu_circle_t'({cen_q[4*COORD_W-1 -: 2*COORD_W], rad_q[2*RAD_W-1 -: RAD_W]});
    assign circ_c = lu_circle_t'({cen_q[2*COORD_W-1 -: 2*COORD_W], rad_q[RAD_W-1 -: RAD_W]});

    // Lane k covers point LANES*beat + k; grid coordinates are 1-based.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [PT_W-1:0]    pt;
        logic [COORD_W-1:0] px;
        logic [COORD_W-1:0] py;

        assign pt = PT_W'(beat_q) * PT_W'(LANES) + PT_W'(k);
        assign px = COORD_W'(pt % PT_W'(GRID)) + COORD_W'(1);
        assign py = COORD_W'(pt / PT_W'(GRID)) + COORD_W'(1);

        lu_point u_point (
            .px_i     (px),
            .py_i     (py),
            .circ_a_i (circ_a),
            .circ_b_i (circ_b),
            .circ_c_i (circ_c),
            .mode_i   (mode_q),
            .hit_o    (lane_hit[k])
        );
    end

    assign scan_act    = (state_q == ST_SCAN);
    assign hit_comb    = scan_act ? lane_hit : '0;
    assign acc_clear_o = (state_q == ST_CLEAR);
    assign busy_o      = (state_q != ST_IDLE) || tail_busy;

`ifdef LU_PIPE_EN
    logic             acc_en_q;
    logic [LANES-1:0] hit_q;
    logic             done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_en_q <= 1'b0;
            hit_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            acc_en_q <= scan_act;
            hit_q    <= hit_comb;
            done_q   <= (state_q == ST_DONE);
        end
    end

    assign tail_busy = done_q;
    assign acc_en_o  = acc_en_q;
    assign hit_o     = hit_q;
    assign done_o    = done_q;
`else
    assign tail_busy = 1'b0;
    assign acc_en_o  = scan_act;
    assign hit_o     = hit_comb;
    assign done_o    = (state_q == ST_DONE);
`endif

endmodule

// File: tb/tb_lu_scan.sv
// Directed bench for lu_scan: vector table of scans with hand-computed hit
// counts, plus restart, re-pulse and mid-scan reset sequences.
module tb_lu_scan;
    import lu_scan_pkg::*;

`ifdef LU_PIPE_EN
    localparam int LAT = 19;
`else
    localparam int LAT = 18;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [23:0] cen = '0;
    logic [11:0] rad = '0;
    logic [1:0]  mode = '0;
    logic        busy, clr, acc_en, done;
    logic [3:0]  hit;

    always #5 clk = ~clk;

    lu_scan dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .central_i   (cen),
        .radius_i    (rad),
        .mode_i      (mode),
        .busy_o      (busy),
        .acc_clear_o (clr),
        .acc_en_o    (acc_en),
        .hit_o       (hit),
        .done_o      (done)
    );

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [23:0] cen;   // {xA,yA,xB,yB,xC,yC}
        logic [11:0] rad;   // {rA,rB,rC}
        int          exp_cnt;
        int          exp_first_beat;
        int          exp_first_hit;
    } vec_t;

    vec_t vecs[9];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Entered #1 after a rising edge with the DUT idle; leaves it idle.
    task automatic run_scan(input vec_t v, input bit repulse);
        int cnt = 0, n_done = 0, done_cyc = -1, n_clr = 0, clr_cyc = -1;
        int n_beats = 0, leak = 0, first_beat = -1, first_hit = 0;
        int busy_start = 0, busy_last = 0, busy_after = 1;
        int cyc;
        mode = v.mode; cen = v.cen; rad = v.rad; en = 1'b1;
        @(posedge clk); #1;
        cyc = 1; en = 1'b0;
        cen = ~v.cen; rad = ~v.rad; mode = ~v.mode;
        while (cyc <= LAT + 3) begin
            if (clr) begin n_clr++; clr_cyc = cyc; end
            if (acc_en) begin
                if (hit != 0 && first_beat < 0) begin
                    first_beat = n_beats; first_hit = int'(hit);
                end
                cnt += $countones(hit);
                n_beats++;
            end else if (hit != 0) leak++;
            if (done) begin n_done++; done_cyc = cyc; end
            if (cyc == 1)       busy_start = int'(busy);
            if (cyc == LAT)     busy_last  = int'(busy);
            if (cyc == LAT + 1) busy_after = int'(busy);
            en = (repulse && (cyc == 7 || cyc == LAT)) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        en = 1'b0;
        check({v.name, "_count"}, cnt, v.exp_cnt);
        check({v.name, "_first_beat"}, first_beat, v.exp_first_beat);
        check({v.name, "_first_hit"}, first_hit, v.exp_first_hit);
        check({v.name, "_beats"}, n_beats, 16);
        check({v.name, "_leak"}, leak, 0);
        check({v.name, "_clear_cyc"}, clr_cyc, 1);
        check({v.name, "_clear_n"}, n_clr, 1);
        check({v.name, "_done_cyc"}, done_cyc, LAT);
        check({v.name, "_done_n"}, n_done, 1);
        check({v.name, "_busy_start"}, busy_start, 1);
        check({v.name, "_busy_last"}, busy_last, 1);
        check({v.name, "_busy_after"}, busy_after, 0);
    endtask

    initial begin
        int cyc, n_done, clr2, zero_ok;
        vecs[0] = '{"m0_r0",      2'd0, 24'h440000, 12'h000,  1,  6, 4'b1000};
        vecs[1] = '{"m0_r15",     2'd0, 24'h440000, 12'hF00, 64,  0, 4'b1111};
        vecs[2] = '{"m1_disjoint",2'd1, 24'h118800, 12'h000,  0, -1, 0};
        vecs[3] = '{"m3_two",     2'd3, 24'h444488, 12'h110,  5,  4, 4'b1000};
        vecs[4] = '{"m2_same",    2'd2, 24'h444488, 12'h110,  0, -1, 0};
        vecs[5] = '{"m0_origin",  2'd0, 24'h000000, 12'h200,  1,  0, 4'b0001};
        vecs[6] = '{"m0_far",     2'd0, 24'hFF0000, 12'hF00, 32,  3, 4'b1000};
        vecs[7] = '{"m2_xor",     2'd2, 24'h112100, 12'h100,  2,  0, 4'b0001};
        vecs[8] = '{"m1_and",     2'd1, 24'h446400, 12'h220,  5,  5, 4'b0001};

        #12;
        check("reset_outputs", int'({busy, clr, acc_en, hit, done}), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_scan(vecs[i], 1'b0);

        // en_i pulsed mid-scan and during DONE: both dropped
        run_scan(vecs[3], 1'b1);

        // en_i held high: the first start after the tail is the next one
        en = 1'b1; cen = vecs[0].cen; rad = vecs[0].rad; mode = vecs[0].mode;
        @(posedge clk); #1;
        cyc = 1; n_done = 0; clr2 = -1;
        while (cyc <= LAT + 4 && clr2 < 0) begin
            if (done) n_done++;
            if (clr && cyc > 1) clr2 = cyc;
            @(posedge clk); #1;
            cyc++;
        end
        en = 1'b0;
        check("hold_en_restart_cyc", clr2, LAT + 2);
        check("hold_en_done_n", n_done, 1);
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("hold_en_idle", int'(busy), 0);

        // reset at beat 8: outputs drop at once, no done afterwards
        en = 1'b1; cen = vecs[1].cen; rad = vecs[1].rad; mode = vecs[1].mode;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("pre_reset_acc_en", int'(acc_en), 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", int'({busy, clr, acc_en, hit, done}), 0);
        zero_ok = 1;
        repeat (3) begin
            @(posedge clk); #1;
            if ({busy, clr, acc_en, hit, done} != 0) zero_ok = 0;
        end
        check("held_reset_outputs", zero_ok, 1);
        @(negedge clk); rst_n = 1'b1;
        n_done = 0;
        repeat (LAT) begin
            @(posedge clk); #1;
            if (done || busy) n_done++;
        end
        check("post_reset_quiet", n_done, 0);
        run_scan(vecs[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lu_scan.md
LU_SCAN -- requirements
Module: lu_scan

Interface
REQ-001 SHALL have parameter LANES, default 4, grid points tested per cycle; must equal `LU_BUS_SZ.
REQ-002 SHALL have parameter GRID, default 8, grid edge length; grid is GRID x GRID, GRID*GRID divisible by LANES.
REQ-003 clk_i  input  1  sole clock, rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 en_i  input  1  start request; sampled only in IDLE.
REQ-006 central_i  input  24  {xA,yA,xB,yB,xC,yC}, 4-bit unsigned each.
REQ-007 radius_i  input  12  {rA,rB,rC}, 4-bit unsigned each.
REQ-008 mode_i  input  2  set function, see REQ-016.
REQ-009 busy_o  output  1  scan in progress.
REQ-010 acc_clear_o  output  1  clear pulse to downstream accumulator.
REQ-011 acc_en_o  output  1  hit_o beat valid.
REQ-012 hit_o  output  LANES  per-lane membership result, bit k = lane k.
REQ-013 done_o  output  1  one-cycle pulse; accumulator count valid this cycle.

Function
REQ-014 FSM states: IDLE, CLEAR, SCAN, DONE; IDLE->CLEAR when en_i=1; CLEAR->SCAN unconditionally; SCAN->DONE after beat GRID*GRID/LANES-1; DONE->IDLE unconditionally.
REQ-015 On the IDLE edge accepting en_i, central_i, radius_i and mode_i SHALL be registered; later input changes have no effect until the next start.
REQ-016 Point (x,y) in circle c iff (x-xc)^2+(y-yc)^2 <= rc^2, computed in 9-bit unsigned; mode 0: in A; 1: in A and B; 2: in exactly one of A,B; 3: in exactly two of A,B,C.
REQ-017 Beat counter b runs 0..15 in SCAN; lane k tests point p=LANES*b+k, x=(p mod GRID)+1, y=(p div GRID)+1.
REQ-018 acc_clear_o SHALL be 1 exactly in CLEAR; acc_en_o SHALL be 1 exactly during the 16 hit beats; hit_o SHALL be 0 whenever acc_en_o=0.
REQ-019 done_o SHALL be 1 for exactly one cycle, the cycle after the last hit beat; start-to-done latency 18 cycles (LU_PIPE_EN undefined).
REQ-020 busy_o SHALL be 1 in CLEAR, SCAN and DONE; en_i while busy_o=1 SHALL be ignored, not queued.
REQ-021 en_i high in DONE SHALL be ignored; en_i high in the cycle after DONE (IDLE) SHALL start a new scan.
REQ-022 Radius 0 SHALL hit only the exact centre; centres outside 1..8 SHALL be handled without overflow.

Reset
REQ-023 rst_ni=0 SHALL force IDLE, beat counter 0, registered parameters 0, and busy_o, acc_clear_o, acc_en_o, hit_o, done_o to 0 asynchronously.
REQ-024 Reset mid-scan SHALL abort with no done_o pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-025 Macro LU_PIPE_EN: defined -> hit_o and acc_en_o registered one extra stage, done_o delayed to keep REQ-019 alignment, latency 19; undefined -> hit combinational from state/counter, latency 18.
REQ-026 With LU_PIPE_EN defined, busy_o SHALL cover the extra cycle, and REQ-018/020 SHALL still hold.

Structure
REQ-027 Mode encodings, GRID, LANES default and coordinate/radius widths SHALL live in the shared def.v header.
REQ-028 Per-point test SHALL be a combinational sub-module lu_point (point, three circles, mode -> hit), instanced LANES times.

Verification
REQ-029 Mode 0, A=(4,4) r=0 -> exactly one hit beat bit set across scan; accumulated count 1; done_o at cycle 18.
REQ-030 Mode 0, A=(4,4) r=15 -> all 16 beats hit_o=4'b1111; count 64.
REQ-031 Mode 1, A=(1,1) r=0, B=(8,8) r=0 -> hit_o always 0; count 0.
REQ-032 Mode 3, A=B=(4,4) r=1, C=(8,8) r=0 -> count 5; mode 2 same circles -> count 0.
REQ-033 en_i re-pulsed at beat 5 -> ignored, single done_o; rst_ni low at beat 8 -> all outputs 0 immediately, no done_o.
REQ-034 Rerun REQ-029..031 with LU_PIPE_EN defined -> identical counts, done_o at cycle 19.
